// File: rtl/interrupt_request_controller.sv
// Interrupt request source: latches rising edges on irq lines, prioritises the lowest
// enabled pending line and handshakes with the hazard control unit until reti.
module interrupt_request_controller #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [13:0] VEC_BASE   = 14'h0010,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic               clock,
    input  logic               nreset,
    input  logic [NUM_IRQ-1:0] irq_lines,
    input  logic               global_enable,
    input  logic               enable_wr_en,
    input  logic [NUM_IRQ-1:0] enable_wr_data,
    input  logic [2:0]         control_state,
    input  logic               reti,
    output logic               interrupt,
    output logic [13:0]        interrupt_vector_address,
    output logic [3:0]         active_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] irq_enable
);

    localparam int unsigned ID_W  = 4;
    localparam int unsigned VEC_W = 14;
    localparam int unsigned EXT_W = 16;
    localparam logic [2:0]  ACK_STATE = 3'h2;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVICE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clear_c;
    logic [EXT_W-1:0]   enable_ext;
    logic [ID_W-1:0]    first_id;
    logic [ID_W-1:0]    active_id_next;
    logic               interrupt_next;
    logic               in_service_next;
    logic [VEC_W-1:0]   vector_next;

    function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
        return VEC_W'(32'(VEC_BASE) + 32'(id) * VEC_STRIDE);
    endfunction

    assign rise       = irq_lines & ~prev;
    assign eligible   = global_enable ? (pending & irq_enable) : '0;
    assign enable_ext = EXT_W'(irq_enable);

    // Lowest set index wins: scan downward so the last hit is the lowest.
    always_comb begin
        first_id = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (eligible[i]) first_id = ID_W'(i);
        end
    end

    always_comb begin
        state_next      = state;
        active_id_next  = active_id;
        interrupt_next  = 1'b0;
        in_service_next = 1'b0;
        vector_next     = '0;
        ack_clear_c     = '0;
        case (state)
            IDLE: begin
                if (eligible != '0) begin
                    state_next     = REQUEST;
                    active_id_next = first_id;
                    interrupt_next = 1'b1;
                    vector_next    = vec_of(first_id);
                end
            end
            REQUEST: begin
                interrupt_next = 1'b1;
                vector_next    = interrupt_vector_address;
                if (control_state == ACK_STATE) begin
                    state_next      = SERVICE;
                    ack_clear_c     = NUM_IRQ'(EXT_W'(1) << active_id);
                    interrupt_next  = 1'b0;
                    in_service_next = 1'b1;
                end else if (!global_enable || !enable_ext[active_id]) begin
                    state_next     = IDLE;
                    interrupt_next = 1'b0;
                    vector_next    = '0;
                end
            end
            SERVICE: begin
                in_service_next = 1'b1;
                vector_next     = interrupt_vector_address;
                if (reti) begin
                    state_next      = IDLE;
                    in_service_next = 1'b0;
                    vector_next     = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new edge on the line being acknowledged keeps its pending bit set.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state                    <= IDLE;
            prev                     <= irq_lines;
            pending                  <= '0;
            irq_enable               <= '0;
            active_id                <= '0;
            interrupt                <= 1'b0;
            in_service               <= 1'b0;
            interrupt_vector_address <= '0;
        end else begin
            state                    <= state_next;
            prev                     <= irq_lines;
            pending                  <= (pending & ~ack_clear_c) | rise;
            if (enable_wr_en) irq_enable <= enable_wr_data;
            active_id                <= active_id_next;
            interrupt                <= interrupt_next;
            in_service               <= in_service_next;
            interrupt_vector_address <= vector_next;
        end
    end

endmodule

// File: doc/interrupt_request_controller.md
Name: interrupt_request_controller

Overview:
- Source side of the pipeline interrupt interface.
- Latches rising edges on external interrupt lines as pending requests, applies per-line and global enables, and selects the highest-priority line (lowest index).
- Drives `interrupt` and `interrupt_vector_address` into the hazard control unit.
- Treats `control_state == 3'h2` (Interrupt state) as acknowledge, and tracks the in-service interrupt until return-from-interrupt. No nesting.

Parameters:
- NUM_IRQ, 8: number of interrupt lines; 1..16.
- VEC_BASE, 14'h0010: vector address of line 0.
- VEC_STRIDE, 4: address spacing between consecutive line vectors.

Ports:
- clock  input  1  system clock; all registers update on the rising edge.
- nreset  input  1  reset, synchronous, active-low.
- irq_lines  input  NUM_IRQ  external interrupt levels, already synchronous to clock.
- global_enable  input  1  master interrupt enable.
- enable_wr_en  input  1  write strobe for the per-line enable register.
- enable_wr_data  input  NUM_IRQ  new enable value; bit=1 means enabled.
- control_state  input  3  hazard control unit state; 3'h2 = acknowledge.
- reti  input  1  one-cycle pulse when a return-from-interrupt retires.
- interrupt  output  1  request to the hazard control unit.
- interrupt_vector_address  output  14  vector of the active request.
- active_id  output  4  index of the requested or in-service line.
- in_service  output  1  handler is executing.
- pending  output  NUM_IRQ  latched pending bits.
- irq_enable  output  NUM_IRQ  per-line enable register.

Behaviour:
- Reset (nreset=0 at a rising edge):
  - pending, irq_enable, active_id, interrupt, in_service all 0; vector 0; FSM goes to IDLE.
  - Edge-detect register loads the current irq_lines, so a line held high through reset produces no pending bit.
- Edge detect:
  - pending[i] sets at the rising edge where irq_lines[i]=1 and prev[i]=0.
  - prev tracks irq_lines every cycle.
  - Pending sets regardless of enables.
- Enable write: irq_enable <= enable_wr_data at the rising edge where enable_wr_en=1. Takes effect on eligibility the following cycle.
- Eligibility: eligible = pending & irq_enable, gated by global_enable.
- FSM (registered outputs):
  - IDLE:
    - interrupt=0, in_service=0.
    - If eligible is nonzero, latch active_id = lowest set index and go to REQUEST.
    - Latency: interrupt asserts 2 edges after the irq edge is sampled (edge 1 sets pending, edge 2 enters REQUEST).
  - REQUEST:
    - interrupt=1; interrupt_vector_address = VEC_BASE + active_id*VEC_STRIDE, truncated to 14 bits and stable for the whole state.
    - If control_state==3'h2: clear pending[active_id], go to SERVICE.
    - Else if global_enable=0 or irq_enable[active_id]=0: withdraw to IDLE; pending is kept.
    - Ack and withdraw in the same cycle: ack wins.
    - A higher-priority edge arriving during REQUEST does not preempt the latched active_id.
  - SERVICE:
    - interrupt=0, in_service=1; active_id is held.
    - reti=1 goes to IDLE; in_service clears on that edge.
    - New edges keep accumulating in pending.
- reti in IDLE or REQUEST is ignored.
- A new edge on the active line in the same cycle pending[active_id] is cleared by ack: set wins, and the bit remains pending.
- Vector output is 0 in IDLE. In SERVICE it holds the last vector.
- active_id is zero-extended to 4 bits.
- Reset mid-REQUEST or mid-SERVICE: synchronous return to IDLE with all outputs at reset values; no ack is generated.

Test Plan (NUM_IRQ=8, VEC_BASE=14'h0010, VEC_STRIDE=4):
- Reset with irq_lines=8'h01 held, release reset, hold 10 cycles -> pending=8'h00, interrupt=0.
- irq_enable=8'hFF, global_enable=1, pulse irq_lines[3] -> pending=8'h08 after 1 edge; interrupt=1 with vector 14'h001C, active_id=3 after the next edge. Then drive control_state=3'h2 for one cycle -> pending=0, interrupt=0, in_service=1. Then pulse reti -> in_service=0.
- Simultaneous edges on lines 5 and 2 -> first request vector 14'h0018 (id 2). After ack + reti, second request vector 14'h0024 (id 5).
- irq_enable=8'h00, edge on line 6 -> pending=8'h40, interrupt stays 0. Write enable=8'h40 -> interrupt=1 with vector 14'h0028 within 2 edges.
- In REQUEST for line 1, drop global_enable with control_state=0 -> interrupt=0 next edge, pending[1]=1. Restore global_enable -> re-request with vector 14'h0014. Repeat with ack and global_enable drop in the same cycle -> SERVICE entered.
- Edge on line 0 in the same cycle as its ack -> pending[0] stays 1, SERVICE entered. After reti, a second request with vector 14'h0010 is issued.
